// File: rtl/brq_mem_arbiter.sv
// Purpose: shares one core-side memory port between the instruction-fetch and
// load/store requesters of a brq_core. Requests are arbitrated (fixed data
// priority or round-robin), the winner is locked until granted, and an
// in-order source FIFO steers each response back to its owner.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   instr_*                        fetch requester (read-only)
//   data_*                         load/store requester
//   mem_*                          shared downstream port (req/gnt/rvalid)
//   unexp_rsp_o                    one-cycle pulse after an rvalid that had
//                                  no outstanding transaction
module brq_mem_arbiter #(
   parameter int unsigned MaxOutstanding = 2,
   parameter logic        DataPriority   = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_ni,

   input  logic        instr_req_i,
   output logic        instr_gnt_o,
   input  logic [31:0] instr_addr_i,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,

   input  logic        data_req_i,
   output logic        data_gnt_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,

   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,

   output logic        unexp_rsp_o
);

   // Storage is sized for the largest legal depth; pointers wrap at MaxOutstanding.
   localparam int unsigned PtrW  = 2;
   localparam int unsigned CntW  = 3;
   localparam int unsigned FifoD = 4;

   localparam logic SEL_INSTR = 1'b0;
   localparam logic SEL_DATA  = 1'b1;

   typedef enum logic {
      ARB  = 1'b0,
      HOLD = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic              sel_q, sel_d;
   logic              rr_last_q, rr_last_d;
   logic [FifoD-1:0]  src_q, src_d;
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic              unexp_q, unexp_d;

   logic              arb_sel_c;
   logic              sel_c;
   logic              req_c;
   logic              push_c;
   logic              pop_c;
   logic              empty_c;
   logic              head_c;

   // Winner of a fresh arbitration round.
   always_comb begin
      arb_sel_c = SEL_INSTR;
      if (instr_req_i && data_req_i) begin
         if (DataPriority) begin
            arb_sel_c = SEL_DATA;
         end else begin
            arb_sel_c = (rr_last_q == SEL_DATA) ? SEL_INSTR : SEL_DATA;
         end
      end else if (data_req_i) begin
         arb_sel_c = SEL_DATA;
      end
   end

   // Next-state and request logic; HOLD keeps an ungranted request locked.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      sel_c   = arb_sel_c;
      req_c   = 1'b0;
      unique case (state_q)
         ARB: begin
            sel_c = arb_sel_c;
            req_c = (instr_req_i | data_req_i) &
                    (count_q < CntW'(MaxOutstanding));
            if (req_c && !mem_gnt_i) begin
               state_d = HOLD;
               sel_d   = arb_sel_c;
            end
         end
         HOLD: begin
            sel_c = sel_q;
            req_c = 1'b1;
            if (mem_gnt_i) begin
               state_d = ARB;
            end
         end
         default: begin
            state_d = ARB;
         end
      endcase
   end

   assign push_c  = req_c & mem_gnt_i;
   assign empty_c = (count_q == '0);
   assign pop_c   = mem_rvalid_i & ~empty_c;
   assign head_c  = src_q[rd_ptr_q];

   // Source FIFO bookkeeping and round-robin history.
   always_comb begin
      src_d     = src_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      rr_last_d = rr_last_q;
      unexp_d   = mem_rvalid_i & empty_c;

      if (push_c) begin
         src_d[wr_ptr_q] = sel_c;
         rr_last_d       = sel_c;
         wr_ptr_d        = (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 :
                           wr_ptr_q + PtrW'(1);
      end
      if (pop_c) begin
         rd_ptr_d = (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 :
                    rd_ptr_q + PtrW'(1);
      end

      unique case ({push_c, pop_c})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ARB;
         sel_q     <= SEL_INSTR;
         rr_last_q <= SEL_DATA;
         src_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         unexp_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         rr_last_q <= rr_last_d;
         src_q     <= src_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         unexp_q   <= unexp_d;
      end
   end

   // Request side: zero-latency mux and grant fan-out, forced low in reset.
   assign mem_req_o   = rst_ni & req_c;
   assign mem_we_o    = rst_ni & (sel_c == SEL_DATA) & data_we_i;
   assign mem_be_o    = !rst_ni ? 4'h0 :
                        (sel_c == SEL_DATA) ? data_be_i : 4'hF;
   assign mem_addr_o  = !rst_ni ? 32'h0 :
                        (sel_c == SEL_DATA) ? data_addr_i : instr_addr_i;
   assign mem_wdata_o = (rst_ni && (sel_c == SEL_DATA)) ? data_wdata_i : 32'h0;

   assign instr_gnt_o = rst_ni & push_c & (sel_c == SEL_INSTR);
   assign data_gnt_o  = rst_ni & push_c & (sel_c == SEL_DATA);

   // Response side: routed by the FIFO head, data/err broadcast to both.
   assign instr_rvalid_o = rst_ni & pop_c & (head_c == SEL_INSTR);
   assign data_rvalid_o  = rst_ni & pop_c & (head_c == SEL_DATA);
   assign instr_rdata_o  = rst_ni ? mem_rdata_i : 32'h0;
   assign data_rdata_o   = rst_ni ? mem_rdata_i : 32'h0;
   assign instr_err_o    = rst_ni & mem_err_i;
   assign data_err_o     = rst_ni & mem_err_i;

   assign unexp_rsp_o = unexp_q;

endmodule
